div_unit: RTL
=============

# div_unit

Iterative 32-bit integer divider for the DIV/DIVU instructions. It takes a start pulse from the decoder together with the two rs/rt operand values and runs a radix-2 restoring division over 32 cycles. While it runs it holds `busy` so the PC update stalls. It then presents the quotient and remainder, which the LO/HI write path and the 4-input register-writeback select consume on the cycle `done` pulses.

## Interface
- No parameters; datapath width is fixed at 32.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a division; sampled on the rising edge of `clk`.
- `sign`  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`.
- `dividend`  input  32  rs value; sampled with `start`.
- `divisor`  input  32  rt value; sampled with `start`.
- `busy`  output  1  division in progress; the PC/write enables stall while this is high.
- `done`  output  1  one-cycle pulse; `quotient`/`remainder` are newly valid.
- `quotient`  output  32  goes to LO.
- `remainder`  output  32  goes to HI.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - On an edge with `start`=1, latch operands and sign mode.
  - Compute |dividend| and |divisor| (magnitudes only when `sign`=1; raw values otherwise).
  - Record result signs: quotient negative = sign && (dividend[31] ^ divisor[31]); remainder negative = sign && dividend[31].
  - Clear the 32-bit partial remainder, set the iteration counter to 0, go to RUN.
- RUN, one iteration per edge:
  - Shift {partial remainder, magnitude dividend} left by 1.
  - Trial subtract: 33-bit (partial remainder − divisor magnitude).
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After iteration 31 (counter = 31), go to FINISH.
- FINISH, one edge:
  - Apply two's-complement negation to quotient and/or remainder per the recorded signs.
  - Register the results onto the outputs, pulse `done`, return to IDLE.
- Divide by zero, detected at latch time:
  - The full 33-cycle sequence still runs, so stall behaviour is uniform.
  - FINISH forces quotient = 0xFFFFFFFF and remainder = original dividend (unsigned or signed alike).
- Signed overflow (0x80000000 / 0xFFFFFFFF with `sign`=1): the natural result is quotient = 0x80000000, remainder = 0; no special trap.
- `start` while `busy`=1 is ignored; operands are not re-latched.
- `quotient`/`remainder` hold their last result until the next FINISH. They never show intermediate values.

## Timing
- Reset (asynchronous, immediate): state = IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, counter = 0.
- Reset mid-division aborts the operation; no `done` is produced.
- Start accepted at edge E0:
  - `busy`=1 from just after E0 through E33.
  - Iterations occur on edges E1..E32.
  - FINISH occurs at E33: outputs update, `done`=1 and `busy`=0 for the cycle after E33.
- Latency: 33 cycles from the accepting edge to valid results.
- `start` at E33 itself is not accepted, since the state is FINISH. The earliest back-to-back start is accepted at E34, i.e. the edge on which `done` is high, because the state is IDLE by then.
- `done` is exactly one cycle wide. `busy` and `done` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned basic: start, sign=0, 100 / 7.
  - Required: `busy` high 33 cycles; `done` pulses once; quotient = 14, remainder = 2.
- Signed mixed: sign=1, 0xFFFFFFF9 (−7) / 2.
  - Required: quotient = 0xFFFFFFFD (−3), remainder = 0xFFFFFFFF (−1).
- Edge values:
  - Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero, sign=1, 0x00001234 / 0.
  - Required: same 33-cycle latency; quotient 0xFFFFFFFF, remainder 0x00001234.
- Handshake:
  - Re-assert `start` with different operands at E5 → ignored; the first result is unchanged.
  - Assert `start` at E34 → second result after a further 33 cycles.
  - Outputs hold the first result until then.
- Reset mid-op: assert `rst` at E10 of a division.
  - Required: immediately `busy`=0, outputs 0, and no `done`.
  - A fresh start after release completes normally.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// One accepting edge, 32 iteration edges, one finish edge; results and
// handshake flags are all registered.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   prem_q, prem_d;     // partial remainder
  logic [W-1:0]   quo_q, quo_d;       // dividend magnitude shifting out, quotient shifting in
  logic [W-1:0]   dvsr_q, dvsr_d;     // divisor magnitude
  logic [W-1:0]   orig_q, orig_d;     // original dividend, returned as remainder on divide by zero
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dz_q, dz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   quotient_q, quotient_d;
  logic [W-1:0]   remainder_q, remainder_d;

  logic [W:0]     shifted;
  logic           take;
  logic [W-1:0]   diff;
  logic [W-1:0]   abs_dividend;
  logic [W-1:0]   abs_divisor;

  // Operand magnitudes; raw values in unsigned mode
  always_comb begin
    abs_dividend = (sign && dividend[W-1]) ? (~dividend + W'(1)) : dividend;
    abs_divisor  = (sign && divisor[W-1])  ? (~divisor + W'(1))  : divisor;
  end

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  // When the trial succeeds the difference is below 2^32, so the low 32 bits
  // of the wrapped subtraction are exact.
  always_comb begin
    shifted = {prem_q, quo_q[W-1]};
    take    = (shifted >= {1'b0, dvsr_q});
    diff    = shifted[W-1:0] - dvsr_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    orig_d      = orig_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dz_d        = dz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          quo_d     = abs_dividend;
          dvsr_d    = abs_divisor;
          orig_d    = dividend;
          neg_quo_d = sign && (dividend[W-1] ^ divisor[W-1]);
          neg_rem_d = sign && dividend[W-1];
          dz_d      = (divisor == '0);
          prem_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end

      RUN: begin
        prem_d = take ? diff : shifted[W-1:0];
        quo_d  = {quo_q[W-2:0], take};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = orig_q;
        end else begin
          quotient_d  = neg_quo_q ? (~quo_q + W'(1))  : quo_q;
          remainder_d = neg_rem_q ? (~prem_q + W'(1)) : prem_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      orig_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      orig_q      <= orig_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
